// File: rtl/wb_arb2.sv
// ---------------------------------------------------------------------------
// wb_arb2 -- two-master to one-slave Wishbone arbiter (pipelined handshake).
//
// Grant is decided on a rising edge and held until the owning master drops
// cyc; ties out of IDLE go to the master that was not granted last. While a
// master owns the bus its request fields pass straight to the slave and the
// slave's responses pass straight back. A per-grant outstanding counter and
// a watchdog produce a one-cycle error to the owner when the slave stays
// silent too long on accepted requests.
//
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   mN_cyc_i/stb_i/we_i            master N (N=0,1) bus cycle, strobe, write
//   mN_adr_i/dat_i/sel_i           master N address, write data, byte selects
//   mN_dat_o                       read data (s_dat_i, valid with ack)
//   mN_ack_o/err_o/stall_o         master N responses
//   s_cyc_o/stb_o/we_o/adr_o/
//   s_dat_o/sel_o                  request to the shared slave
//   s_dat_i/ack_i/err_i/stall_i    response from the shared slave
//   gnt_o                          one-hot grant, 00 when idle
// ---------------------------------------------------------------------------
module wb_arb2 #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int GRANULE    = 8,
  parameter int TIMEOUT    = 15,
  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // master 0
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  input  logic [SEL_WIDTH-1:0]  m0_sel_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_stall_o,
  // master 1
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  input  logic [SEL_WIDTH-1:0]  m1_sel_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_stall_o,
  // shared slave
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  output logic [SEL_WIDTH-1:0]  s_sel_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_stall_i,
  // grant
  output logic [1:0]            gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic       last_q, last_d;     // master that held the bus most recently
  logic [7:0] out_q;              // requests accepted but not yet answered
  logic [7:0] wd_q;               // cycles without a response while out_q != 0
  logic       to_pulse_q;         // timeout error owed to the current owner

  logic own0, own1;
  logic accept, resp, grant_change, wd_hit;

  // Reset removes ownership combinationally so an aborted transfer sees no
  // response and the slave sees cyc drop in the same cycle.
  assign own0 = (state_q == GNT0) && !rst_i;
  assign own1 = (state_q == GNT1) && !rst_i;

  // -------------------------------------------------------------------------
  // Grant FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_d = GNT0;
        else if (m1_cyc_i)        state_d = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Request mux and response routing
  // -------------------------------------------------------------------------
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (own0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
    end else if (own1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
    end
  end

  assign gnt_o      = {own1, own0};
  assign m0_dat_o   = s_dat_i;
  assign m1_dat_o   = s_dat_i;
  assign m0_ack_o   = own0 & s_ack_i;
  assign m1_ack_o   = own1 & s_ack_i;
  assign m0_err_o   = own0 & (s_err_i | to_pulse_q);
  assign m1_err_o   = own1 & (s_err_i | to_pulse_q);
  assign m0_stall_o = own0 ? s_stall_i : 1'b1;
  assign m1_stall_o = own1 ? s_stall_i : 1'b1;

  // -------------------------------------------------------------------------
  // Outstanding counter and watchdog
  // -------------------------------------------------------------------------
  assign accept       = s_cyc_o & s_stb_o & ~s_stall_i;
  assign resp         = s_ack_i | s_err_i;
  assign grant_change = (state_d != state_q);
  // A slave response in the same cycle as the would-be timeout wins.
  assign wd_hit       = !resp && (out_q != 8'd0) && ((wd_q + 8'd1) == TO_LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      out_q      <= 8'd0;
      wd_q       <= 8'd0;
      to_pulse_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      last_q     <= last_d;
      to_pulse_q <= wd_hit && !grant_change;
      if (grant_change || wd_hit) begin
        out_q <= 8'd0;
        wd_q  <= 8'd0;
      end else begin
        // Accept and response in the same cycle cancel; a response with
        // nothing outstanding is forwarded but not counted.
        if (accept && !resp) begin
          if (out_q != 8'hFF) out_q <= out_q + 8'd1;
        end else if (!accept && resp && (out_q != 8'd0)) begin
          out_q <= out_q - 8'd1;
        end
        if ((out_q == 8'd0) || resp) wd_q <= 8'd0;
        else if (wd_q != 8'hFF)      wd_q <= wd_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_arb2.sv
module tb_wb_arb2;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 15;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic [SW-1:0] m0_sel_i, m1_sel_i, s_sel_o;
  logic          m0_ack_o, m0_err_o, m0_stall_o, m1_ack_o, m1_err_o, m1_stall_o;
  logic          s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, s_stall_i;
  logic [1:0]    gnt_o;

  always #5 clk_i = ~clk_i;

  wb_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_stall_o(m0_stall_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_stall_o(m1_stall_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i),
    .gnt_o(gnt_o)
  );

  typedef struct packed {
    logic rst, c0, s0, w0, c1, s1, w1, ack, err, stall;
  } drv_t;

  typedef struct {
    drv_t       d;
    logic [1:0] gnt;
    logic       s_cyc, a0, e0, st0, a1, e1, st1;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model: who owns the bus, how many requests
  // are unanswered, how long the slave has been silent ----------------------
  int mo_owner = 0;   // 0 none, 1 master0, 2 master1
  int mo_last  = 1;
  int mo_out   = 0;
  int mo_wd    = 0;
  bit mo_pulse = 0;

  task automatic step_model(input drv_t d);
    int  nxt, n_out, n_wd;
    bit  acc, resp, hit, changed;
    if (d.rst) begin
      mo_owner = 0; mo_last = 1; mo_out = 0; mo_wd = 0; mo_pulse = 0;
      return;
    end
    acc  = ((mo_owner == 1 && d.c0 && d.s0) || (mo_owner == 2 && d.c1 && d.s1)) && !d.stall;
    resp = d.ack || d.err;
    nxt  = mo_owner;
    if (mo_owner == 0) begin
      if (d.c0 && d.c1) nxt = (mo_last == 1) ? 1 : 2;
      else if (d.c0)    nxt = 1;
      else if (d.c1)    nxt = 2;
    end else if (mo_owner == 1 && !d.c0) begin
      mo_last = 0; nxt = d.c1 ? 2 : 0;
    end else if (mo_owner == 2 && !d.c1) begin
      mo_last = 1; nxt = d.c0 ? 1 : 0;
    end
    changed = (nxt != mo_owner);
    hit     = !resp && mo_out > 0 && (mo_wd + 1 == TO);
    n_out   = mo_out;
    if (acc && !resp)                  n_out = (mo_out < 255) ? mo_out + 1 : 255;
    else if (!acc && resp && mo_out > 0) n_out = mo_out - 1;
    n_wd    = (mo_out == 0 || resp) ? 0 : mo_wd + 1;
    if (changed || hit) begin n_out = 0; n_wd = 0; end
    mo_pulse = hit && !changed;
    mo_out   = n_out;
    mo_wd    = n_wd;
    mo_owner = nxt;
  endtask

  function automatic logic [127:0] model_vec(input drv_t d);
    int         own;
    logic [1:0] g;
    logic       sc, ss, sw, a0, e0, st0, a1, e1, st1;
    logic [AW-1:0] ad;
    logic [DW-1:0] dt;
    logic [SW-1:0] sl;
    own = d.rst ? 0 : mo_owner;
    g   = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
    sc  = (own == 1) ? d.c0 : (own == 2) ? d.c1 : 1'b0;
    ss  = (own == 1) ? d.s0 : (own == 2) ? d.s1 : 1'b0;
    sw  = (own == 1) ? d.w0 : (own == 2) ? d.w1 : 1'b0;
    ad  = (own == 1) ? m0_adr_i : (own == 2) ? m1_adr_i : '0;
    dt  = (own == 1) ? m0_dat_i : (own == 2) ? m1_dat_i : '0;
    sl  = (own == 1) ? m0_sel_i : (own == 2) ? m1_sel_i : '0;
    a0  = (own == 1) && d.ack;
    e0  = (own == 1) && (d.err || mo_pulse);
    st0 = (own == 1) ? d.stall : 1'b1;
    a1  = (own == 2) && d.ack;
    e1  = (own == 2) && (d.err || mo_pulse);
    st1 = (own == 2) ? d.stall : 1'b1;
    return {1'b0, g, sc, ss, sw, ad, dt, sl, a0, e0, st0, a1, e1, st1, s_dat_i, s_dat_i};
  endfunction

  function automatic logic [127:0] dut_vec();
    return {1'b0, gnt_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
            m0_ack_o, m0_err_o, m0_stall_o, m1_ack_o, m1_err_o, m1_stall_o,
            m0_dat_o, m1_dat_o};
  endfunction

  // Drive one cycle's inputs just after an edge and settle before the next.
  task automatic pre(input drv_t d);
    rst_i = d.rst;
    m0_cyc_i = d.c0; m0_stb_i = d.s0; m0_we_i = d.w0;
    m1_cyc_i = d.c1; m1_stb_i = d.s1; m1_we_i = d.w1;
    s_ack_i = d.ack; s_err_i = d.err; s_stall_i = d.stall;
    m0_adr_i = AW'($urandom); m1_adr_i = AW'($urandom);
    m0_dat_i = $urandom;      m1_dat_i = $urandom;
    m0_sel_i = SW'($urandom); m1_sel_i = SW'($urandom);
    s_dat_i  = $urandom;
    #6;
  endtask

  task automatic post(input drv_t d);
    @(posedge clk_i);
    step_model(d);
    #1;
  endtask

  function automatic drv_t mk(input bit rst, c0, s0, w0, c1, s1, w1, ack, err, stall);
    drv_t d;
    d = '{rst, c0, s0, w0, c1, s1, w1, ack, err, stall};
    return d;
  endfunction

  // Silent-slave tracker: returns the offset of the first err seen, how many
  // err cycles, and whether any ack showed up, for the given master.
  task automatic silent_run(input int m, input int n, input int ack_at,
                            output int first_err, output int errs, output int acks);
    drv_t d;
    first_err = -1; errs = 0; acks = 0;
    for (int off = 1; off <= n; off++) begin
      d = mk(0, m == 0, 0, 0, m == 1, 0, 0, off == ack_at, 0, 0);
      pre(d);
      if ((m == 0 ? m0_err_o : m1_err_o) === 1'b1) begin
        if (first_err < 0) first_err = off;
        errs++;
      end
      if ((m == 0 ? m0_ack_o : m1_ack_o) === 1'b1) acks++;
      post(d);
    end
  endtask

  vec_t vt[15];
  initial begin
    drv_t d;
    int   fe, ne, na, bad;

    // rst c0 s0 w0 c1 s1 w1 ack err stall | gnt cyc a0 e0 st0 a1 e1 st1
    vt[0]  = '{mk(1,1,0,0,1,0,0,0,0,0), 2'b00, 0, 0,0,1, 0,0,1};
    vt[1]  = '{mk(0,1,0,0,1,0,0,0,0,0), 2'b00, 0, 0,0,1, 0,0,1};
    vt[2]  = '{mk(0,1,0,0,1,0,0,0,0,0), 2'b01, 1, 0,0,0, 0,0,1};
    vt[3]  = '{mk(0,0,0,0,1,0,0,0,0,0), 2'b01, 0, 0,0,0, 0,0,1};
    vt[4]  = '{mk(0,1,0,0,1,0,0,0,0,0), 2'b10, 1, 0,0,1, 0,0,0};
    vt[5]  = '{mk(0,1,0,0,0,0,0,0,0,0), 2'b10, 0, 0,0,1, 0,0,0};
    vt[6]  = '{mk(0,1,0,0,1,0,0,0,0,0), 2'b01, 1, 0,0,0, 0,0,1};
    vt[7]  = '{mk(0,1,1,0,1,1,0,0,0,0), 2'b01, 1, 0,0,0, 0,0,1};
    vt[8]  = '{mk(0,1,1,0,1,1,0,0,0,0), 2'b01, 1, 0,0,0, 0,0,1};
    vt[9]  = '{mk(0,1,1,1,1,1,0,0,0,0), 2'b01, 1, 0,0,0, 0,0,1};
    vt[10] = '{mk(0,1,0,0,1,0,0,1,0,0), 2'b01, 1, 1,0,0, 0,0,1};
    vt[11] = '{mk(0,1,0,0,1,0,0,1,0,0), 2'b01, 1, 1,0,0, 0,0,1};
    vt[12] = '{mk(0,1,0,0,1,0,0,1,0,0), 2'b01, 1, 1,0,0, 0,0,1};
    vt[13] = '{mk(0,1,0,0,1,0,0,0,1,0), 2'b01, 1, 0,1,0, 0,0,1};
    vt[14] = '{mk(0,1,0,0,1,0,0,0,0,1), 2'b01, 1, 0,0,1, 0,0,1};

    for (int i = 0; i < 15; i++) begin
      pre(vt[i].d);
      check($sformatf("vec%0d", i),
            {119'd0, gnt_o, s_cyc_o, m0_ack_o, m0_err_o, m0_stall_o, m1_ack_o, m1_err_o, m1_stall_o},
            {119'd0, vt[i].gnt, vt[i].s_cyc, vt[i].a0, vt[i].e0, vt[i].st0, vt[i].a1, vt[i].e1, vt[i].st1});
      post(vt[i].d);
    end

    // Three acks drained the counter: holding m0 with m1 requesting must
    // produce no timeout, no preemption and nothing for m1.
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      d = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      pre(d);
      if (m0_err_o !== 1'b0 || gnt_o !== 2'b01 || m1_ack_o !== 1'b0 || m1_stall_o !== 1'b1) bad++;
      post(d);
    end
    check("drained_hold", 128'(bad), 128'd0);

    // Timeout on master 1: one accepted strobe, silent slave.
    d = mk(1,0,0,0,0,0,0,0,0,0); pre(d); post(d);
    d = mk(0,0,0,0,1,0,0,0,0,0); pre(d); post(d);
    d = mk(0,0,0,0,1,1,0,0,0,0); pre(d);
    check("m1_gnt_at_accept", 128'(gnt_o), 128'(2'b10));
    post(d);
    silent_run(1, 40, 0, fe, ne, na);
    check("to_offset", 128'(fe), 128'd16);
    check("to_width", 128'(ne), 128'd1);
    check("to_no_ack", 128'(na), 128'd0);
    check("to_keeps_gnt", 128'(gnt_o), 128'(2'b10));

    // Slave ack in the timeout cycle beats the watchdog.
    d = mk(1,0,0,0,0,0,0,0,0,0); pre(d); post(d);
    d = mk(0,0,0,0,1,0,0,0,0,0); pre(d); post(d);
    d = mk(0,0,0,0,1,1,0,0,0,0); pre(d); post(d);
    silent_run(1, 40, 15, fe, ne, na);
    check("race_no_err", 128'(ne), 128'd0);
    check("race_ack", 128'(na), 128'd1);

    // Stalled strobe is not counted; acceptance on first stall-free cycle.
    d = mk(1,0,0,0,0,0,0,0,0,0); pre(d); post(d);
    d = mk(0,1,0,0,0,0,0,0,0,0); pre(d); post(d);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      d = mk(0,1,1,0,0,0,0,0,0,1);
      pre(d);
      if (m0_stall_o !== 1'b1 || m0_err_o !== 1'b0) bad++;
      post(d);
    end
    check("stall_hold", 128'(bad), 128'd0);
    d = mk(0,1,1,0,0,0,0,0,0,0); pre(d);
    check("stall_free", 128'(m0_stall_o), 128'd0);
    post(d);
    silent_run(0, 40, 0, fe, ne, na);
    check("stall_to_offset", 128'(fe), 128'd16);

    // Reset with two outstanding on m0 aborts the grant at once.
    d = mk(0,1,0,0,0,0,0,0,0,0); pre(d); post(d);
    d = mk(0,1,1,0,0,0,0,0,0,0); pre(d); post(d);
    d = mk(0,1,1,0,0,0,0,0,0,0); pre(d); post(d);
    d = mk(1,1,0,0,0,0,0,1,0,0); pre(d);
    check("rst_mid", {120'd0, gnt_o, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m0_stall_o, 1'b0},
                     {120'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    post(d);
    d = mk(0,1,0,0,0,0,0,1,0,0); pre(d);
    check("rst_after", {123'd0, gnt_o, s_cyc_o, m0_ack_o, m0_err_o},
                       {123'd0, 2'b00, 1'b0, 1'b0, 1'b0});
    post(d);
    silent_run(0, 30, 0, fe, ne, na);
    check("rst_out_clear", 128'(ne), 128'd0);
    check("rst_regrant", 128'(gnt_o), 128'(2'b01));

    // Randomized traffic against the reference model.
    begin
      int rpct, epct;
      rpct = 10; epct = 3;
      for (int i = 0; i < 3000; i++) begin
        if (i % 200 == 0) begin
          rpct = $urandom_range(0, 2) * 10;
          epct = $urandom_range(0, 3);
        end
        d.rst   = ($urandom_range(0, 99) < 1);
        d.c0    = ($urandom_range(0, 99) < 75);
        d.s0    = $urandom_range(0, 1);
        d.w0    = $urandom_range(0, 1);
        d.c1    = ($urandom_range(0, 99) < 75);
        d.s1    = $urandom_range(0, 1);
        d.w1    = $urandom_range(0, 1);
        d.ack   = ($urandom_range(0, 99) < rpct);
        d.err   = ($urandom_range(0, 99) < epct);
        d.stall = ($urandom_range(0, 99) < 30);
        pre(d);
        check($sformatf("rand%0d", i), dut_vec(), model_vec(d));
        post(d);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
